// File: rtl/gray_seq_monitor_pkg.sv
// Shared types for the Gray-code sequence monitor: FSM states, step classes and widths.
package gray_seq_monitor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACQ  = 2'd1,
      ST_LOCK = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      STEP_GOOD   = 2'd0,
      STEP_REPEAT = 2'd1,
      STEP_BAD    = 2'd2
   } step_e;

   // Good-step counter width; LOCK_COUNT is limited to 1..15.
   localparam int GOOD_W = 4;

endpackage

// File: rtl/gray_seq_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   logic [WIDTH-1:0] acc;

   always_comb begin
      acc            = '0;
      acc[WIDTH-1]   = gray_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         acc[i] = acc[i+1] ^ gray_i[i];
      end
      bin_o = acc;
   end

endmodule

// File: rtl/gray_seq_monitor.sv
// Registers a Gray-code stream, decodes it and flags samples that are not +/-1 from the previous one.
// Tracks direction, lock after LOCK_COUNT good steps, and a saturating error count.
module gray_seq_monitor
   import gray_seq_monitor_pkg::*;
#(
   parameter int WIDTH      = 4,
   parameter int LOCK_COUNT = 2,
   parameter int ERR_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr_err,
   output logic             out_valid,
   output logic [WIDTH-1:0] bin_out,
   output logic             dir_up,
   output logic             step_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count
);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    prev_q, prev_d;
   logic [GOOD_W-1:0]   good_q, good_d;
   logic                dir_q, dir_d;
   logic                out_valid_q, out_valid_d;
   logic                step_err_q, step_err_d;
   logic [ERR_W-1:0]    err_q, err_d;

   logic [WIDTH-1:0]    cur_bin;
   logic [WIDTH-1:0]    diff;
   logic [GOOD_W-1:0]   good_inc;
   step_e               step;
   logic                step_up;
   logic                bad;

   gray_to_bin #(.WIDTH(WIDTH)) u_dec (
      .gray_i (gray_in),
      .bin_o  (cur_bin)
   );

   // Modular difference: +1 and -1 (all ones) are adjacent, so wrap-around is legal.
   always_comb begin
      diff    = cur_bin - prev_q;
      step_up = (diff == WIDTH'(1));
      if (diff == WIDTH'(1) || diff == '1) begin
         step = STEP_GOOD;
      end else if (diff == '0) begin
         step = STEP_REPEAT;
      end else begin
         step = STEP_BAD;
      end
   end

   assign good_inc = good_q + GOOD_W'(1);

   // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      good_d      = good_q;
      dir_d       = dir_q;
      out_valid_d = 1'b0;
      step_err_d  = 1'b0;
      bad         = 1'b0;

      if (in_valid) begin
         out_valid_d = 1'b1;
         prev_d      = cur_bin;
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_ACQ;
               good_d  = '0;
            end
            ST_ACQ: begin
               if (step == STEP_GOOD) begin
                  dir_d  = step_up;
                  good_d = good_inc;
                  if (good_inc >= GOOD_W'(LOCK_COUNT)) begin
                     state_d = ST_LOCK;
                  end
               end else if (step == STEP_BAD) begin
                  bad        = 1'b1;
                  step_err_d = 1'b1;
                  good_d     = '0;
               end
            end
            ST_LOCK: begin
               if (step == STEP_GOOD) begin
                  dir_d = step_up;
               end else if (step == STEP_BAD) begin
                  bad        = 1'b1;
                  step_err_d = 1'b1;
                  good_d     = '0;
                  state_d    = ST_ACQ;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A clear coinciding with an error leaves exactly that one error counted.
      err_d = err_q;
      if (clr_err) begin
         err_d = bad ? ERR_W'(1) : '0;
      end else if (bad && err_q != '1) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         prev_q      <= '0;
         good_q      <= '0;
         dir_q       <= 1'b0;
         out_valid_q <= 1'b0;
         step_err_q  <= 1'b0;
         err_q       <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         good_q      <= good_d;
         dir_q       <= dir_d;
         out_valid_q <= out_valid_d;
         step_err_q  <= step_err_d;
         err_q       <= err_d;
      end
   end

   // The previous sample is also the last accepted decode.
   assign bin_out   = prev_q;
   assign out_valid = out_valid_q;
   assign dir_up    = dir_q;
   assign step_err  = step_err_q;
   assign locked    = (state_q == ST_LOCK);
   assign err_count = err_q;

endmodule

// File: tb/tb_gray_seq_monitor.sv
// Self-checking bench for gray_seq_monitor: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against a behavioural model.
module tb_gray_seq_monitor;

   localparam int W  = 4;
   localparam int LC = 2;
   localparam int EW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  gray_in = '0;
   logic          clr_err = 1'b0;
   logic          out_valid;
   logic [W-1:0]  bin_out;
   logic          dir_up;
   logic          step_err;
   logic          locked;
   logic [EW-1:0] err_count;

   int  checks = 0;
   int  errors = 0;
   bit  cmp_en = 1'b0;
   int  last_bin = 0;

   gray_seq_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_W(EW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .gray_in   (gray_in),
      .clr_err   (clr_err),
      .out_valid (out_valid),
      .bin_out   (bin_out),
      .dir_up    (dir_up),
      .step_err  (step_err),
      .locked    (locked),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          out_valid;
      logic [W-1:0]  bin;
      logic          dir;
      logic          step_err;
      logic          locked;
      logic [EW-1:0] err;
      logic          have;
      int            good;
   } model_t;

   model_t m;

   function automatic int decode(input logic [W-1:0] g);
      int x = int'(g);
      return x ^ (x >> 1) ^ (x >> 2) ^ (x >> 3);
   endfunction

   function automatic logic [W-1:0] gray_of(input int b);
      int x = b & 15;
      return W'(x ^ (x >> 1));
   endfunction

   function automatic model_t model_step(input model_t s, input logic v, input logic [W-1:0] g,
                                         input logic c);
      model_t n = s;
      int cur;
      int diff;
      bit bad = 1'b0;
      n.out_valid = v;
      n.step_err  = 1'b0;
      if (v) begin
         cur = decode(g);
         if (!s.have) begin
            n.have   = 1'b1;
            n.good   = 0;
            n.locked = 1'b0;
         end else begin
            diff = (cur - int'(s.bin) + 16) % 16;
            if (diff == 1 || diff == 15) begin
               n.dir  = (diff == 1);
               n.good = s.good + 1;
               if (n.good >= LC) n.locked = 1'b1;
            end else if (diff != 0) begin
               bad        = 1'b1;
               n.step_err = 1'b1;
               n.good     = 0;
               n.locked   = 1'b0;
            end
         end
         n.bin = W'(cur);
      end
      if (c) n.err = bad ? EW'(1) : EW'(0);
      else if (bad && s.err != 8'd255) n.err = s.err + EW'(1);
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= '0;
      else        m <= model_step(m, in_valid, gray_in, clr_err);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_out_valid", 32'(out_valid), 32'(m.out_valid));
         check("cmp_bin_out",   32'(bin_out),   32'(m.bin));
         check("cmp_dir_up",    32'(dir_up),    32'(m.dir));
         check("cmp_step_err",  32'(step_err),  32'(m.step_err));
         check("cmp_locked",    32'(locked),    32'(m.locked));
         check("cmp_err_count", 32'(err_count), 32'(m.err));
      end
   end

   task automatic cyc(input logic v, input logic [W-1:0] g, input logic c);
      @(negedge clk);
      #1;
      in_valid = v;
      gray_in  = g;
      clr_err  = c;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_err  = 1'b0;
   endtask

   // Reset spans one rising edge with a random sample presented, which must be dropped.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      gray_in  = W'($urandom);
      @(negedge clk);
      #2;
      rst_n    = 1'b1;
      in_valid = 1'b0;
   endtask

   initial begin
      do_reset();
      cmp_en = 1'b1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_bin_out",   32'(bin_out),   32'd0);
      check("rst_locked",    32'(locked),    32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);

      // Counting up from 0 locks on the third sample.
      cyc(1'b1, 4'b0000, 1'b0);
      check("t1_valid0", 32'(out_valid), 32'd1);
      check("t1_bin0",   32'(bin_out),   32'd0);
      check("t1_lock0",  32'(locked),    32'd0);
      cyc(1'b1, 4'b0001, 1'b0);
      check("t1_bin1",   32'(bin_out),   32'd1);
      check("t1_dir1",   32'(dir_up),    32'd1);
      cyc(1'b1, 4'b0011, 1'b0);
      check("t1_bin2",   32'(bin_out),   32'd2);
      check("t1_lock2",  32'(locked),    32'd1);
      check("t1_err2",   32'(step_err),  32'd0);

      // Wrap 15 -> 0 is an up step, 0 -> 15 a down step.
      do_reset();
      cyc(1'b1, 4'b1011, 1'b0);
      cyc(1'b1, 4'b1001, 1'b0);
      cyc(1'b1, 4'b1000, 1'b0);
      check("t2_bin15",  32'(bin_out),   32'd15);
      check("t2_lock15", 32'(locked),    32'd1);
      cyc(1'b1, 4'b0000, 1'b0);
      check("t2_wrap_bin", 32'(bin_out),  32'd0);
      check("t2_wrap_dir", 32'(dir_up),   32'd1);
      check("t2_wrap_err", 32'(step_err), 32'd0);
      cyc(1'b1, 4'b1000, 1'b0);
      check("t2_back_bin", 32'(bin_out),  32'd15);
      check("t2_back_dir", 32'(dir_up),   32'd0);
      check("t2_back_lck", 32'(locked),   32'd1);

      // 1 -> 5 breaks lock; 6 and 7 reacquire it.
      cyc(1'b1, 4'b0000, 1'b0);
      cyc(1'b1, 4'b0001, 1'b0);
      check("t3_lock_pre", 32'(locked),    32'd1);
      cyc(1'b1, 4'b0111, 1'b0);
      check("t3_bad_bin",  32'(bin_out),   32'd5);
      check("t3_bad_err",  32'(step_err),  32'd1);
      check("t3_bad_cnt",  32'(err_count), 32'd1);
      check("t3_bad_lck",  32'(locked),    32'd0);
      cyc(1'b0, 4'b0000, 1'b0);
      check("t3_pulse",    32'(step_err),  32'd0);
      check("t3_idle_ov",  32'(out_valid), 32'd0);
      check("t3_idle_bin", 32'(bin_out),   32'd5);
      cyc(1'b1, 4'b0101, 1'b0);
      check("t3_six_lck",  32'(locked),    32'd0);
      cyc(1'b1, 4'b0100, 1'b0);
      check("t3_seven",    32'(bin_out),   32'd7);
      check("t3_relock",   32'(locked),    32'd1);

      // Repeated sample is neither an error nor a direction change.
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0);
      cyc(1'b1, 4'b0001, 1'b0);
      cyc(1'b1, 4'b0011, 1'b0);
      cyc(1'b1, 4'b0011, 1'b0);
      check("t4_rep_ov",  32'(out_valid), 32'd1);
      check("t4_rep_err", 32'(step_err),  32'd0);
      check("t4_rep_lck", 32'(locked),    32'd1);
      check("t4_rep_dir", 32'(dir_up),    32'd1);
      cyc(1'b1, 4'b0001, 1'b0);
      check("t4_down",    32'(dir_up),    32'd0);
      cyc(1'b1, 4'b0001, 1'b0);
      check("t4_rep_dn",  32'(dir_up),    32'd0);

      // Asynchronous reset while locked clears outputs before any clock edge.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5_async_bin", 32'(bin_out), 32'd0);
      check("t5_async_lck", 32'(locked),  32'd0);
      check("t5_async_dir", 32'(dir_up),  32'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      cyc(1'b1, 4'b0110, 1'b0);
      check("t5_first_ov",  32'(out_valid), 32'd1);
      check("t5_first_err", 32'(step_err),  32'd0);
      check("t5_first_bin", 32'(bin_out),   32'd4);
      cyc(1'b1, 4'b0111, 1'b0);
      check("t5_acq_lck",   32'(locked),    32'd0);
      cyc(1'b1, 4'b0101, 1'b0);
      check("t5_lock",      32'(locked),    32'd1);

      // Saturate the error counter, then exercise both clear cases.
      do_reset();
      cyc(1'b1, 4'b0000, 1'b0);
      for (int i = 0; i < 255; i++) begin
         cyc(1'b1, (i % 2 == 0) ? 4'b1100 : 4'b0000, 1'b0);
      end
      check("t6_cnt255",  32'(err_count), 32'd255);
      cyc(1'b1, 4'b0000, 1'b0);
      check("t6_sat",     32'(err_count), 32'd255);
      check("t6_sat_err", 32'(step_err),  32'd1);
      cyc(1'b1, 4'b1100, 1'b1);
      check("t6_clr_bad", 32'(err_count), 32'd1);
      cyc(1'b0, 4'b0000, 1'b1);
      check("t6_clr",     32'(err_count), 32'd0);

      // Randomized stream biased toward legal steps, with occasional clears and resets.
      last_bin = 0;
      for (int n = 0; n < 3000; n++) begin
         int k;
         int b;
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
         end else begin
            k = $urandom_range(0, 9);
            if (k < 4)       b = last_bin + 1;
            else if (k < 7)  b = last_bin + 15;
            else if (k == 7) b = last_bin;
            else             b = $urandom_range(0, 15);
            b = b % 16;
            if ($urandom_range(0, 3) != 0) begin
               last_bin = b;
               cyc(1'b1, gray_of(b), 1'($urandom_range(0, 19) == 0));
            end else begin
               cyc(1'b0, gray_of(b), 1'($urandom_range(0, 19) == 0));
            end
         end
      end

      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
